wb_pipe_stage: RTL and testbench

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage.sv | 154 +++++++++++++++
 tb/tb_wb_pipe_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// Writeback pipeline stage: one-entry capture register between MEM and the register file,
// with retirement counting and a forwarding entry. Define WB_LOAD_EXT_EN to enable load extraction.
module wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] link_addr,
    input  logic [1:0]        wb_sel,
    input  logic              reg_write,
    input  logic [RA_W-1:0]   rd_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [1:0]        byte_off,
    output logic [DATA_W-1:0] r3_din,
    output logic [RA_W-1:0]   r3_addr,
    output logic              o_RegWrite,
    output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retire_cnt
);

`ifdef WB_LOAD_EXT_EN
    // Picks the addressed lane of the low word and sign/zero extends it to the datapath width.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  off
    );
        logic [7:0]        lane_b;
        logic [15:0]       lane_h;
        logic [DATA_W-1:0] res;
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            2'd3:    lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? DATA_W'(lane_b) : DATA_W'($signed(lane_b));
            2'b01:   res = uns ? DATA_W'(lane_h) : DATA_W'($signed(lane_h));
            default: res = uns ? DATA_W'(word)   : DATA_W'($signed(word));
        endcase
        return res;
    endfunction
`endif

    logic              valid_r;
    logic              reg_write_r;
    logic [DATA_W-1:0] r3_din_r;
    logic [RA_W-1:0]   r3_addr_r;
    logic              fwd_valid_r;
    logic [RA_W-1:0]   fwd_addr_r;
    logic [DATA_W-1:0] fwd_data_r;
    logic [31:0]       retire_cnt_r;

    logic [DATA_W-1:0] mem_data_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              accept_s;
    logic              retire_s;
    logic              wr_en_s;
    logic              unused_s;

    // Load inputs only matter with extraction enabled; the upper memory bits never feed a load lane.
    assign unused_s = ^{mem_rdata, ld_size, ld_unsigned, byte_off};

    // Memory-source data: lane extraction when enabled, otherwise the raw read data.
    always_comb begin
        mem_data_s = mem_rdata;
`ifdef WB_LOAD_EXT_EN
        mem_data_s = load_extract(mem_rdata[31:0], ld_size, ld_unsigned, byte_off);
`endif
    end

    // Writeback source mux; the spare encoding falls back to the ALU result.
    always_comb begin
        sel_data_s = alu_out;
        case (wb_sel)
            2'b01:   sel_data_s = mem_data_s;
            2'b10:   sel_data_s = link_addr;
            default: sel_data_s = alu_out;
        endcase
    end

    // Handshake, retirement and write-enable qualification.
    always_comb begin
        accept_s = in_valid && !hold && !flush;
        retire_s = valid_r && !hold;
        if (valid_r && reg_write_r && !hold && (r3_addr_r != {RA_W{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Capture register: flush beats hold, hold freezes, otherwise accept or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            r3_din_r    <= {DATA_W{1'b0}};
            r3_addr_r   <= {RA_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (!hold) begin
            valid_r <= accept_s;
            if (accept_s) begin
                reg_write_r <= reg_write;
                r3_din_r    <= sel_data_s;
                r3_addr_r   <= rd_addr;
            end
        end
    end

    // Retirement counter and forwarding entry; only real register writes refresh forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= 32'd0;
            fwd_valid_r  <= 1'b0;
            fwd_addr_r   <= {RA_W{1'b0}};
            fwd_data_r   <= {DATA_W{1'b0}};
        end else begin
            if (retire_s) begin
                retire_cnt_r <= retire_cnt_r + 32'd1;
            end
            if (wr_en_s) begin
                fwd_valid_r <= 1'b1;
                fwd_addr_r  <= r3_addr_r;
                fwd_data_r  <= r3_din_r;
            end
        end
    end

    assign in_ready   = !hold;
    assign o_RegWrite = wr_en_s;
    assign r3_din     = r3_din_r;
    assign r3_addr    = r3_addr_r;
    assign fwd_valid  = fwd_valid_r;
    assign fwd_addr   = fwd_addr_r;
    assign fwd_data   = fwd_data_r;
    assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench for wb_pipe_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_wb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] alu_out = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] link_addr = 32'd0;
    logic [1:0]  wb_sel = 2'd0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd_addr = 5'd0;
    logic [1:0]  ld_size = 2'd0;
    logic        ld_unsigned = 1'b0;
    logic [1:0]  byte_off = 2'd0;
    logic [31:0] r3_din;
    logic [4:0]  r3_addr;
    logic        o_RegWrite;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    wb_pipe_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .hold(hold), .flush(flush), .alu_out(alu_out), .mem_rdata(mem_rdata),
        .link_addr(link_addr), .wb_sel(wb_sel), .reg_write(reg_write), .rd_addr(rd_addr),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned), .byte_off(byte_off),
        .r3_din(r3_din), .r3_addr(r3_addr), .o_RegWrite(o_RegWrite),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        rw;
    } ent_t;

    ent_t        held[$];
    int unsigned m_cnt;
    logic        m_fv;
    logic [4:0]  m_fa;
    logic [31:0] m_fd;

    function automatic logic [31:0] exp_sel(input logic [1:0] sel, input logic [31:0] a,
                                            input logic [31:0] m, input logic [31:0] l,
                                            input logic [1:0] sz, input logic uns,
                                            input logic [1:0] off);
        int unsigned w;
        int unsigned v;
        w = m;
        if (sz == 2'd0) begin
            v = (w >> (8 * int'(off))) % 32'd256;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * (int'(off) / 2))) % 32'd65536;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        if (sel == 2'b10) return l;
        if (sel != 2'b01) return a;
`ifdef WB_LOAD_EXT_EN
        return v;
`else
        return (v == w) ? m : m;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        held.delete();
        m_cnt = 0;
        m_fv = 1'b0;
        m_fa = 5'd0;
        m_fd = 32'd0;
    endtask

    task automatic model_edge();
        ent_t e;
        if (held.size() > 0 && !hold) begin
            m_cnt = m_cnt + 1;
            if (held[0].rw && held[0].addr != 5'd0) begin
                m_fv = 1'b1;
                m_fa = held[0].addr;
                m_fd = held[0].data;
            end
        end
        if (flush) begin
            held.delete();
        end else if (!hold) begin
            held.delete();
            if (in_valid) begin
                e.data = exp_sel(wb_sel, alu_out, mem_rdata, link_addr, ld_size, ld_unsigned, byte_off);
                e.addr = rd_addr;
                e.rw   = reg_write;
                held.push_back(e);
            end
        end
    endtask

    task automatic model_compare();
        logic exp_we;
        exp_we = (held.size() > 0) && held[0].rw && !hold && (held[0].addr != 5'd0);
        chk("in_ready", {63'd0, in_ready}, {63'd0, !hold});
        chk("o_RegWrite", {63'd0, o_RegWrite}, {63'd0, exp_we});
        chk("retire_cnt", {32'd0, retire_cnt}, {32'd0, m_cnt});
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, m_fv});
        if (m_fv) begin
            chk("fwd_addr", {59'd0, fwd_addr}, {59'd0, m_fa});
            chk("fwd_data", {32'd0, fwd_data}, {32'd0, m_fd});
        end
        if (held.size() > 0) begin
            chk("r3_din", {32'd0, r3_din}, {32'd0, held[0].data});
            chk("r3_addr", {59'd0, r3_addr}, {59'd0, held[0].addr});
        end
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic tick();
        #1;
        model_compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input logic iv, input logic h, input logic f, input logic [1:0] sel,
                          input logic [31:0] a, input logic [4:0] rd, input logic rw);
        in_valid = iv; hold = h; flush = f; wb_sel = sel;
        alu_out = a; rd_addr = rd; reg_write = rw;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst r3_din", {32'd0, r3_din}, 64'd0);
        chk("rst r3_addr", {59'd0, r3_addr}, 64'd0);
        chk("rst o_RegWrite", {63'd0, o_RegWrite}, 64'd0);
        chk("rst fwd_valid", {63'd0, fwd_valid}, 64'd0);
        chk("rst fwd_addr", {59'd0, fwd_addr}, 64'd0);
        chk("rst fwd_data", {32'd0, fwd_data}, 64'd0);
        chk("rst retire_cnt", {32'd0, retire_cnt}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_case(input logic [1:0] sz, input logic uns, input logic [1:0] off,
                             input logic [31:0] exp_ext, input string name);
        set_in(1'b1, 1'b0, 1'b0, 2'b01, 32'h0BAD_0BAD, 5'd12, 1'b1);
        mem_rdata = 32'h80FF_7F01; ld_size = sz; ld_unsigned = uns; byte_off = off;
        tick();
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
        #1;
`ifdef WB_LOAD_EXT_EN
        chk(name, {32'd0, r3_din}, {32'd0, exp_ext});
`else
        chk(name, {32'd0, r3_din}, {32'd0, (exp_ext == 32'd0) ? 32'h80FF_7F01 : 32'h80FF_7F01});
`endif
        tick();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        async_reset();

        // Basic write: accepted on the first edge after reset.
        set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'h1234_5678, 5'd3, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
        #1;
        chk("basic r3_din", {32'd0, r3_din}, 64'h1234_5678);
        chk("basic r3_addr", {59'd0, r3_addr}, 64'd3);
        chk("basic we", {63'd0, o_RegWrite}, 64'd1);
        tick();
        #1;
        chk("basic cnt", {32'd0, retire_cnt}, 64'd1);
        chk("basic fwd_addr", {59'd0, fwd_addr}, 64'd3);
        chk("basic fwd_data", {32'd0, fwd_data}, 64'h1234_5678);

        // Write to x0 is suppressed but still retires.
        set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 5'd0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
        #1;
        chk("x0 we", {63'd0, o_RegWrite}, 64'd0);
        tick();
        #1;
        chk("x0 cnt", {32'd0, retire_cnt}, 64'd2);
        chk("x0 fwd_addr", {59'd0, fwd_addr}, 64'd3);
        chk("x0 fwd_data", {32'd0, fwd_data}, 64'h1234_5678);

        // Link source, then hold for three cycles.
        set_in(1'b1, 1'b0, 1'b0, 2'b10, 32'h1111_1111, 5'd5, 1'b1);
        link_addr = 32'hA5A5_A5A5;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 2'b00, 32'h7777_0000 + i, 5'd9, 1'b1);
            #1;
            chk("hold we", {63'd0, o_RegWrite}, 64'd0);
            chk("hold ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
        #1;
        chk("hold release we", {63'd0, o_RegWrite}, 64'd1);
        chk("hold release din", {32'd0, r3_din}, 64'hA5A5_A5A5);
        chk("hold release addr", {59'd0, r3_addr}, 64'd5);
        tick();
        #1;
        chk("hold after we", {63'd0, o_RegWrite}, 64'd0);
        chk("hold cnt", {32'd0, retire_cnt}, 64'd3);

        // Flush together with hold and a new offer.
        set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0077, 5'd7, 1'b1);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_0088, 5'd8, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
            #1;
            chk("flush we", {63'd0, o_RegWrite}, 64'd0);
            chk("flush cnt", {32'd0, retire_cnt}, 64'd3);
            tick();
        end

        load_case(2'b00, 1'b0, 2'd2, 32'hFFFF_FFFF, "load byte signed");
        load_case(2'b00, 1'b1, 2'd3, 32'h0000_0080, "load byte unsigned");
        load_case(2'b01, 1'b0, 2'd2, 32'hFFFF_80FF, "load half signed");

        // Reset arriving while an entry is held discards it.
        set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0099, 5'd9, 1'b1);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_00AA, 5'd10, 1'b1);
        async_reset();
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
        #1;
        chk("post-reset we", {63'd0, o_RegWrite}, 64'd0);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            hold        = ($urandom_range(0, 9) < 3);
            flush       = ($urandom_range(0, 15) == 0);
            wb_sel      = 2'($urandom_range(0, 3));
            alu_out     = $urandom;
            mem_rdata   = $urandom;
            link_addr   = $urandom;
            reg_write   = ($urandom_range(0, 3) != 0);
            rd_addr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld_size     = 2'($urandom_range(0, 3));
            ld_unsigned = 1'($urandom_range(0, 1));
            byte_off    = 2'($urandom_range(0, 3));
            if (c == 1500) begin
                async_reset();
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
